// File: rtl/multiport_register_file.sv
// Multi-port register file: NRD combinational read ports, two prioritised write ports and a
// per-register busy scoreboard. Optional write-to-read bypass enabled by defining RFILE_BYPASS_EN.
module multiport_register_file #(
   parameter  int DATA_W   = 32,
   parameter  int NREGS    = 32,
   parameter  int NRD      = 2,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(NREGS)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  wen0,
   input  logic [AW-1:0]         wsel0,
   input  logic [DATA_W-1:0]     wdat0,
   input  logic                  wen1,
   input  logic [AW-1:0]         wsel1,
   input  logic [DATA_W-1:0]     wdat1,
   input  logic [NRD*AW-1:0]     rsel,
   output logic [NRD*DATA_W-1:0] rdat,
   output logic [NRD-1:0]        rbusy,
   input  logic                  mark_en,
   input  logic [AW-1:0]         mark_sel,
   output logic [NREGS-1:0]      busy
);

   localparam logic [AW:0] NREGS_X = (AW+1)'(NREGS);

   logic [DATA_W-1:0] r_regs [NREGS];
   logic [NREGS-1:0]  r_busy;

   logic              w_wv0;
   logic              w_wv1;
   logic              w_mv;
   logic [AW-1:0]     w_sel;

   // A select is usable when it addresses a physical register that is not the hardwired zero.
   function automatic logic sel_ok(input logic [AW-1:0] s);
      return ({1'b0, s} < NREGS_X) && !((ZERO_REG != 0) && (s == '0));
   endfunction

   assign w_wv0 = wen0 && sel_ok(wsel0);
   assign w_wv1 = wen1 && sel_ok(wsel1);
   assign w_mv  = mark_en && sel_ok(mark_sel);
   assign busy  = r_busy;

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int r = 0; r < NREGS; r++) begin
            r_regs[r] <= '0;
         end
         r_busy <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            // Port 1 is assigned last so it wins a same-address collision.
            if (w_wv0 && (wsel0 == AW'(r))) r_regs[r] <= wdat0;
            if (w_wv1 && (wsel1 == AW'(r))) r_regs[r] <= wdat1;
            if (w_mv && (mark_sel == AW'(r))) begin
               r_busy[r] <= 1'b1;
            end else if ((w_wv0 && (wsel0 == AW'(r))) || (w_wv1 && (wsel1 == AW'(r)))) begin
               r_busy[r] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      rdat  = '0;
      rbusy = '0;
      w_sel = '0;
      for (int i = 0; i < NRD; i++) begin
         w_sel = rsel[i*AW +: AW];
         if (sel_ok(w_sel)) begin
            rdat[i*DATA_W +: DATA_W] = r_regs[w_sel];
            rbusy[i]                 = r_busy[w_sel];
`ifdef RFILE_BYPASS_EN
            // A same-cycle writer satisfies the reader; only a fresh mark keeps it busy.
            if (!RST && w_wv1 && (wsel1 == w_sel)) begin
               rdat[i*DATA_W +: DATA_W] = wdat1;
               rbusy[i]                 = w_mv && (mark_sel == w_sel);
            end else if (!RST && w_wv0 && (wsel0 == w_sel)) begin
               rdat[i*DATA_W +: DATA_W] = wdat0;
               rbusy[i]                 = w_mv && (mark_sel == w_sel);
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file (NREGS=24, NRD=3): directed vector table, hand sequences,
// then randomized traffic against an array-based reference model.
module tb_multiport_register_file;

   localparam int DW = 32;
   localparam int NR = 24;
   localparam int ND = 3;
   localparam int AW = 5;

   logic           CLK;
   logic           RST;
   logic           wen0, wen1, mark_en;
   logic [AW-1:0]  wsel0, wsel1, mark_sel;
   logic [DW-1:0]  wdat0, wdat1;
   logic [ND*AW-1:0] rsel;
   logic [ND*DW-1:0] rdat;
   logic [ND-1:0]  rbusy;
   logic [NR-1:0]  busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] m_regs [32];
   logic          m_busy [32];

   multiport_register_file #(.DATA_W(DW), .NREGS(NR), .NRD(ND), .ZERO_REG(1)) dut (
      .CLK(CLK), .RST(RST),
      .wen0(wen0), .wsel0(wsel0), .wdat0(wdat0),
      .wen1(wen1), .wsel1(wsel1), .wdat1(wdat1),
      .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
      .mark_en(mark_en), .mark_sel(mark_sel), .busy(busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst;
      logic        wen0;
      logic [4:0]  ws0;
      logic [31:0] wd0;
      logic        wen1;
      logic [4:0]  ws1;
      logic [31:0] wd1;
      logic        mk;
      logic [4:0]  ms;
      logic [4:0]  rs0;
      logic [31:0] exp_rd;
      logic        exp_rb;
      logic [23:0] exp_busy;
   } vec_t;

   vec_t tbl [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit wvalid(input logic en, input logic [4:0] s);
      return en && (int'(s) < NR) && (s != 0);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] s);
      if (int'(s) >= NR || s == 0) return 32'h0;
`ifdef RFILE_BYPASS_EN
      if (!RST && wvalid(wen1, wsel1) && wsel1 == s) return wdat1;
      if (!RST && wvalid(wen0, wsel0) && wsel0 == s) return wdat0;
`endif
      return m_regs[s];
   endfunction

   function automatic logic m_rbusy(input logic [4:0] s);
      if (int'(s) >= NR || s == 0) return 1'b0;
`ifdef RFILE_BYPASS_EN
      if (!RST && ((wvalid(wen1, wsel1) && wsel1 == s) || (wvalid(wen0, wsel0) && wsel0 == s)))
         return mark_en && (mark_sel == s);
`endif
      return m_busy[s];
   endfunction

   function automatic logic [31:0] m_busyvec();
      logic [31:0] v;
      v = '0;
      for (int r = 0; r < NR; r++) v[r] = m_busy[r];
      return v;
   endfunction

   // Sample combinational outputs mid-cycle and compare all ports with the model.
   task automatic sample(input bit do_chk);
      @(negedge CLK);
      if (do_chk) begin
         for (int i = 0; i < ND; i++) begin
            chk($sformatf("rdat%0d sel=%0d", i, rsel[i*AW +: AW]), rdat[i*DW +: DW], m_read(rsel[i*AW +: AW]));
            chk($sformatf("rbusy%0d sel=%0d", i, rsel[i*AW +: AW]), 32'(rbusy[i]), 32'(m_rbusy(rsel[i*AW +: AW])));
         end
         chk("busy_vec", 32'(busy), m_busyvec());
      end
   endtask

   task automatic edge_step();
      @(posedge CLK);
      if (RST) begin
         for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
         end
      end else begin
         if (wvalid(wen0, wsel0)) begin m_regs[wsel0] = wdat0; m_busy[wsel0] = 1'b0; end
         if (wvalid(wen1, wsel1)) begin m_regs[wsel1] = wdat1; m_busy[wsel1] = 1'b0; end
         if (wvalid(mark_en, mark_sel)) m_busy[mark_sel] = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      RST = 0; wen0 = 0; wen1 = 0; mark_en = 0;
      wsel0 = 0; wsel1 = 0; mark_sel = 0; wdat0 = 0; wdat1 = 0;
   endtask

   initial begin
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = 'x;
         m_busy[r] = 1'bx;
      end
      idle();
      rsel = '0;
      RST  = 1;
      sample(0);
      edge_step();
      idle();

      // Reset state: every port and the scoreboard read zero.
      rsel = {5'd23, 5'd10, 5'd1};
      sample(1);
      chk("reset_rdat", rdat[31:0] | rdat[63:32] | rdat[95:64], 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      edge_step();

      tbl.push_back('{0,1, 5,32'hDEADBEEF,0, 0,32'h0,   0, 0, 3,32'h0,       0,24'h0});
      tbl.push_back('{1,0, 0,32'h0,       0, 0,32'h0,   0, 0, 5,32'hDEADBEEF,0,24'h0});
      tbl.push_back('{0,0, 0,32'h0,       0, 0,32'h0,   0, 0, 5,32'h0,       0,24'h0});
      tbl.push_back('{0,1, 0,32'h1234,    0, 0,32'h0,   1, 0, 0,32'h0,       0,24'h0});
      tbl.push_back('{0,0, 0,32'h0,       0, 0,32'h0,   0, 0, 0,32'h0,       0,24'h0});
      tbl.push_back('{0,1, 7,32'h11,      1, 7,32'h22,  0, 0, 5,32'h0,       0,24'h0});
      tbl.push_back('{0,1, 3,32'h33,      1, 4,32'h44,  0, 0, 7,32'h22,      0,24'h0});
      tbl.push_back('{0,0, 0,32'h0,       0, 0,32'h0,   0, 0, 3,32'h33,      0,24'h0});
      tbl.push_back('{0,0, 0,32'h0,       0, 0,32'h0,   0, 0, 4,32'h44,      0,24'h0});
      tbl.push_back('{0,0, 0,32'h0,       0, 0,32'h0,   1, 9, 9,32'h0,       0,24'h0});
      tbl.push_back('{0,0, 0,32'h0,       0, 0,32'h0,   0, 0, 9,32'h0,       1,24'h000200});
      tbl.push_back('{0,0, 0,32'h0,       1, 9,32'hA5,  0, 0, 4,32'h44,      0,24'h000200});
      tbl.push_back('{0,0, 0,32'h0,       0, 0,32'h0,   0, 0, 9,32'hA5,      0,24'h0});
      tbl.push_back('{0,1, 9,32'h5A,      0, 0,32'h0,   1, 9, 3,32'h33,      0,24'h0});
      tbl.push_back('{0,0, 0,32'h0,       0, 0,32'h0,   0, 0, 9,32'h5A,      1,24'h000200});
      tbl.push_back('{0,1,30,32'hFFFF,    1,31,32'hEEEE,1,30,30,32'h0,       0,24'h000200});
      tbl.push_back('{0,0, 0,32'h0,       0, 0,32'h0,   0, 0, 6,32'h0,       0,24'h000200});
      tbl.push_back('{0,0, 0,32'h0,       0, 0,32'h0,   0, 0, 7,32'h22,      0,24'h000200});
      tbl.push_back('{1,1, 9,32'h77,      0, 0,32'h0,   0, 0, 9,32'h5A,      1,24'h000200});
      tbl.push_back('{0,0, 0,32'h0,       0, 0,32'h0,   0, 0, 9,32'h0,       0,24'h0});

      foreach (tbl[k]) begin
         RST = tbl[k].rst;
         wen0 = tbl[k].wen0; wsel0 = tbl[k].ws0; wdat0 = tbl[k].wd0;
         wen1 = tbl[k].wen1; wsel1 = tbl[k].ws1; wdat1 = tbl[k].wd1;
         mark_en = tbl[k].mk; mark_sel = tbl[k].ms;
         rsel = {5'd7, 5'd9, tbl[k].rs0};
         sample(1);
         chk($sformatf("vec%0d rdat0", k), rdat[31:0], tbl[k].exp_rd);
         chk($sformatf("vec%0d rbusy0", k), 32'(rbusy[0]), 32'(tbl[k].exp_rb));
         chk($sformatf("vec%0d busy", k), 32'(busy), 32'(tbl[k].exp_busy));
         edge_step();
      end

      // Write to r12 while port 0 reads it: bypass shows the value this cycle, otherwise next.
      idle();
      wen1 = 1; wsel1 = 12; wdat1 = 32'hCAFE;
      rsel = {5'd0, 5'd0, 5'd12};
      sample(1);
`ifdef RFILE_BYPASS_EN
      chk("bypass_same_cycle", rdat[31:0], 32'hCAFE);
`else
      chk("nobypass_same_cycle", rdat[31:0], 32'h0);
`endif
      edge_step();
      idle();
      sample(1);
      chk("write_next_cycle", rdat[31:0], 32'hCAFE);
      edge_step();

      // Both ports to r13 with a read of r13 and a mark of r13 in the same cycle.
      wen0 = 1; wsel0 = 13; wdat0 = 32'h1;
      wen1 = 1; wsel1 = 13; wdat1 = 32'h2;
      mark_en = 1; mark_sel = 13;
      rsel = {5'd13, 5'd12, 5'd13};
      sample(1);
`ifdef RFILE_BYPASS_EN
      chk("bypass_priority", rdat[31:0], 32'h2);
      chk("bypass_mark_busy", 32'(rbusy[0]), 32'h1);
`else
      chk("collision_old", rdat[31:0], 32'h0);
`endif
      edge_step();
      idle();
      sample(1);
      chk("collision_r13", rdat[31:0], 32'h2);
      chk("mark_beats_write", 32'(rbusy[0]), 32'h1);
      edge_step();

      for (int c = 0; c < 500; c++) begin
         RST      = ($urandom_range(0, 39) == 0);
         wen0     = 1'($urandom);
         wsel0    = 5'($urandom_range(0, 31));
         wdat0    = $urandom;
         wen1     = 1'($urandom);
         wsel1    = ($urandom_range(0, 3) == 0) ? wsel0 : 5'($urandom_range(0, 31));
         wdat1    = $urandom;
         mark_en  = ($urandom_range(0, 2) == 0);
         mark_sel = ($urandom_range(0, 3) == 0) ? wsel0 : 5'($urandom_range(0, 31));
         for (int i = 0; i < ND; i++) begin
            rsel[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? wsel1 : 5'($urandom_range(0, 31));
         end
         sample(1);
         edge_step();
      end

      idle();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
